// File: rtl/bus_responder_if.sv
// ============================================================================
// Module   : bus_responder_if
// Purpose  : Request/response bus bundle between an initiator and the
//            bus_responder target, plus the target's scoreboard counters.
// Ports    : req_valid/req_ready/req_rw/req_addr/req_wdata  request channel
//            rsp_valid/rsp_ready/rsp_rdata/rsp_err          response channel
//            txn_count/err_count                            status counters
//            modport master : initiator side
//            modport slave  : target side
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bus_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [15:0]       txn_count;
   logic [7:0]        err_count;

   modport master (
      output req_valid, req_rw, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, txn_count, err_count
   );

   modport slave (
      input  req_valid, req_rw, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, txn_count, err_count
   );
endinterface

`default_nettype wire

// File: rtl/bus_responder.sv
// ============================================================================
// Module   : bus_responder
// Purpose  : Memory-mapped target. Accepts one request at a time, waits a
//            fixed number of cycles, then answers with read data or a write
//            acknowledgement. Backed by a resettable register array; keeps a
//            wrapping completion counter and a saturating error counter.
// Ports    : clk    in   clock, rising edge
//            rst_n  in   asynchronous active-low reset
//            bus    slave modport of bus_responder_if
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_responder #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int WAIT   = 2
) (
   input logic             clk,
   input logic             rst_n,
   bus_responder_if.slave  bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0]      C_WAIT_CNT = 4'(WAIT);
   localparam logic [ADDR_W:0] C_DEPTH    = (ADDR_W+1)'(DEPTH);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic [15:0]       txn_count_q, txn_count_d;
   logic [7:0]        err_count_q, err_count_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;

   logic accept;
   logic load;
   logic handshake;
   logic addr_ok;

   // RESP is entered with rsp_valid still low; the first cycle in RESP
   // performs the memory access and raises rsp_valid (the "load" step).
   assign accept    = (state_q == S_IDLE) && req_ready_q && bus.req_valid;
   assign load      = (state_q == S_RESP) && !rsp_valid_q;
   assign handshake = (state_q == S_RESP) && rsp_valid_q && bus.rsp_ready;
   // Zero-extended compare: no aliasing of upper address bits, and correct
   // even when DEPTH == 2**ADDR_W.
   assign addr_ok   = ({1'b0, addr_q} < C_DEPTH);
   assign mem_we    = load && rw_q && addr_ok;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (WAIT == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = C_WAIT_CNT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (handshake) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output / datapath next values
   // ------------------------------------------------------------------
   always_comb begin
      // req_ready tracks the upcoming state, so it rises on the first edge
      // out of reset and again on the handshake edge.
      req_ready_d = (state_d == S_IDLE);
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      txn_count_d = txn_count_q;
      err_count_d = err_count_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;

      if (accept) begin
         rw_d    = bus.req_rw;
         addr_d  = bus.req_addr;
         wdata_d = bus.req_wdata;
      end

      if (load) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = !addr_ok;
         rsp_rdata_d = (addr_ok && !rw_q) ? mem_q[addr_q[IDX_W-1:0]] : '0;
      end

      if (handshake) begin
         rsp_valid_d = 1'b0;
         rsp_rdata_d = '0;
         rsp_err_d   = 1'b0;
         txn_count_d = txn_count_q + 16'd1;
         if (rsp_err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         txn_count_q <= 16'd0;
         err_count_q <= 8'd0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         txn_count_q <= txn_count_d;
         err_count_q <= err_count_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if (mem_we) begin
            mem_q[addr_q[IDX_W-1:0]] <= wdata_q;
         end
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.txn_count = txn_count_q;
   assign bus.err_count = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_responder.sv
// ============================================================================
// Module   : tb_bus_responder
// Purpose  : Self-checking bench for bus_responder. Directed steps plus
//            random traffic against a word-array reference model; a second
//            instance built with WAIT=0 covers the minimum-latency case.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_responder;

   localparam int WAIT  = 2;
   localparam int DEPTH = 16;
   localparam int LIMIT = 40;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   bus_responder_if #(.ADDR_W(8), .DATA_W(32)) bus  ();
   bus_responder_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();

   bus_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH), .WAIT(WAIT)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   bus_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH), .WAIT(0)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
   );

   // Reference model: word array and the two counters.
   logic [31:0] m_mem [DEPTH];
   int          m_txn;
   int          m_err;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
      m_txn = 0;
      m_err = 0;
   endtask

   // One full transaction on the WAIT=2 instance. hold = cycles rsp_ready
   // stays low after rsp_valid; poke = present a competing request meanwhile.
   task automatic do_txn(input logic rw, input logic [7:0] addr, input logic [31:0] wdata,
                         input int hold, input bit poke);
      logic [31:0] e_rdata;
      logic        e_err;
      int          n;
      e_err   = (int'(addr) >= DEPTH);
      e_rdata = (!rw && !e_err) ? m_mem[addr[3:0]] : 32'd0;

      bus.req_rw    = rw;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_valid = 1'b1;
      bus.rsp_ready = (hold == 0);
      n = 0;
      while (bus.req_ready !== 1'b1 && n < LIMIT) begin cyc(); n++; end
      check("accept_timeout", 64'(n < LIMIT), 64'd1);
      cyc();                                   // accept edge
      bus.req_valid = 1'b0;
      bus.req_wdata = $urandom;                // captured value must be used
      bus.req_addr  = 8'($urandom);
      check("ready_after_accept", 64'(bus.req_ready), 64'd0);

      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < LIMIT) begin cyc(); n++; end
      check("latency", 64'(n), 64'(WAIT + 1));
      check("rdata", 64'(bus.rsp_rdata), 64'(e_rdata));
      check("err", 64'(bus.rsp_err), 64'(e_err));

      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            bus.req_valid = 1'b1;
            bus.req_rw    = 1'b1;
            bus.req_addr  = addr ^ 8'd1;
         end
         cyc();
         check("hold_valid", 64'(bus.rsp_valid), 64'd1);
         check("hold_rdata", 64'(bus.rsp_rdata), 64'(e_rdata));
         check("hold_err", 64'(bus.rsp_err), 64'(e_err));
         check("hold_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      cyc();                                   // handshake edge
      bus.rsp_ready = 1'b0;

      m_txn = (m_txn + 1) & 32'hFFFF;
      if (e_err) m_err = (m_err < 255) ? m_err + 1 : 255;
      else if (rw) m_mem[addr[3:0]] = wdata;

      check("post_valid", 64'(bus.rsp_valid), 64'd0);
      check("post_rdata", 64'(bus.rsp_rdata), 64'd0);
      check("post_err", 64'(bus.rsp_err), 64'd0);
      check("post_ready", 64'(bus.req_ready), 64'd1);
      check("txn_count", 64'(bus.txn_count), 64'(m_txn));
      check("err_count", 64'(bus.err_count), 64'(m_err));
   endtask

   // Transaction on the WAIT=0 instance with explicit expected response.
   task automatic txn0(input logic rw, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] e_rdata, input logic e_err);
      int n;
      bus0.req_rw    = rw;
      bus0.req_addr  = addr;
      bus0.req_wdata = wdata;
      bus0.req_valid = 1'b1;
      n = 0;
      while (bus0.req_ready !== 1'b1 && n < LIMIT) begin cyc(); n++; end
      check("w0_accept_timeout", 64'(n < LIMIT), 64'd1);
      cyc();
      bus0.req_valid = 1'b0;
      check("w0_ready_drop", 64'(bus0.req_ready), 64'd0);
      check("w0_valid_early", 64'(bus0.rsp_valid), 64'd0);
      cyc();
      check("w0_valid", 64'(bus0.rsp_valid), 64'd1);
      check("w0_rdata", 64'(bus0.rsp_rdata), 64'(e_rdata));
      check("w0_err", 64'(bus0.rsp_err), 64'(e_err));
      bus0.rsp_ready = 1'b1;
      cyc();
      bus0.rsp_ready = 1'b0;
      check("w0_post_valid", 64'(bus0.rsp_valid), 64'd0);
      check("w0_post_ready", 64'(bus0.req_ready), 64'd1);
   endtask

   initial begin
      logic [7:0]  a;
      logic [31:0] d;
      int          n;

      bus.req_valid  = 1'b0; bus.req_rw  = 1'b0; bus.req_addr  = 8'd0;
      bus.req_wdata  = 32'd0; bus.rsp_ready = 1'b0;
      bus0.req_valid = 1'b0; bus0.req_rw = 1'b0; bus0.req_addr = 8'd0;
      bus0.req_wdata = 32'd0; bus0.rsp_ready = 1'b0;
      model_reset();

      // Reset state.
      cyc(); cyc();
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
      check("rst_txn", 64'(bus.txn_count), 64'd0);
      check("rst_errc", 64'(bus.err_count), 64'd0);
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", 64'(bus.req_ready), 64'd0);
      cyc();
      check("ready_after_release", 64'(bus.req_ready), 64'd1);

      // Every implemented word reads back zero.
      for (int i = 0; i < DEPTH; i++) do_txn(1'b0, 8'(i), 32'd0, 0, 1'b0);

      // Write then read back.
      do_txn(1'b1, 8'd3, 32'hDEADBEEF, 0, 1'b0);
      do_txn(1'b0, 8'd3, 32'd0, 0, 1'b0);

      // Out-of-range accesses, then saturation of the error counter.
      do_txn(1'b0, 8'd16, 32'd0, 0, 1'b0);
      do_txn(1'b1, 8'hFF, 32'hCAFEF00D, 0, 1'b0);
      do_txn(1'b0, 8'd15, 32'd0, 0, 1'b0);
      for (int i = 0; i < 300; i++)
         do_txn(1'($urandom), 8'($urandom_range(16, 255)), $urandom, 0, 1'b0);
      check("err_saturated", 64'(bus.err_count), 64'hFF);

      // Backpressure with a competing request presented meanwhile.
      do_txn(1'b1, 8'd7, 32'h0BADC0DE, 5, 1'b1);
      do_txn(1'b0, 8'd7, 32'd0, 5, 1'b1);

      // Reset while a write sits in its wait states.
      bus.req_rw = 1'b1; bus.req_addr = 8'd5; bus.req_wdata = 32'h1234;
      bus.req_valid = 1'b1;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < LIMIT) begin cyc(); n++; end
      check("mid_accept_timeout", 64'(n < LIMIT), 64'd1);
      cyc();
      bus.req_valid = 1'b0;
      cyc();
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 64'(bus.req_ready), 64'd0);
      check("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
      check("mid_rst_txn", 64'(bus.txn_count), 64'd0);
      check("mid_rst_errc", 64'(bus.err_count), 64'd0);
      model_reset();
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
      check("mid_rst_txn_after", 64'(bus.txn_count), 64'd0);
      do_txn(1'b0, 8'd5, 32'd0, 0, 1'b0);

      // Random traffic, mostly in range with some errors and backpressure.
      for (int i = 0; i < 80; i++) begin
         a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
         d = $urandom;
         do_txn(1'($urandom), a, d, int'($urandom_range(0, 3)), 1'($urandom));
      end

      // Completion counter wrap.
      force u_dut.txn_count_q = 16'hFFFF;
      #1;
      release u_dut.txn_count_q;
      m_txn = 32'hFFFF;
      check("txn_preload", 64'(bus.txn_count), 64'hFFFF);
      do_txn(1'b0, 8'd1, 32'd0, 0, 1'b0);
      check("txn_wrapped", 64'(bus.txn_count), 64'd0);

      // Zero wait-state instance.
      txn0(1'b1, 8'd2, 32'hA5A50001, 32'd0, 1'b0);
      txn0(1'b0, 8'd2, 32'd0, 32'hA5A50001, 1'b0);
      txn0(1'b0, 8'd20, 32'd0, 32'd0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
